// File: rtl/sram_rmw_arbiter_if.sv
// rtl/sram_rmw_arbiter_if.sv - requester and SRAM-side bus bundle for sram_rmw_arbiter
//
// Purpose: groups both requester ports and the SRAM wrapper connection.
//   slave  : the arbiter's view (requests in, grants/read data/SRAM controls out)
//   master : the requesters/SRAM side (drives requests and SRAM read data)
// Signals:
//   ReqN_SI/GntN_SO/WeN_SI/AddrN_DI/BEnN_SI/WDataN_DI/RValidN_SO/RDataN_DO  requester N
//   Busy_SO                                                              merge write in progress
//   CSel_SO/WrEn_SO/Addr_DO/WrData_DO/RdData_DI                          SRAM wrapper
interface sram_rmw_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
);
    localparam int NB = DATA_W / 8;

    logic              Req0_SI,    Req1_SI;
    logic              Gnt0_SO,    Gnt1_SO;
    logic              We0_SI,     We1_SI;
    logic [ADDR_W-1:0] Addr0_DI,   Addr1_DI;
    logic [NB-1:0]     BEn0_SI,    BEn1_SI;
    logic [DATA_W-1:0] WData0_DI,  WData1_DI;
    logic              RValid0_SO, RValid1_SO;
    logic [DATA_W-1:0] RData0_DO,  RData1_DO;
    logic              Busy_SO;
    logic              CSel_SO;
    logic              WrEn_SO;
    logic [ADDR_W-1:0] Addr_DO;
    logic [DATA_W-1:0] WrData_DO;
    logic [DATA_W-1:0] RdData_DI;

    modport slave (
        input  Req0_SI, Req1_SI, We0_SI, We1_SI, Addr0_DI, Addr1_DI,
               BEn0_SI, BEn1_SI, WData0_DI, WData1_DI, RdData_DI,
        output Gnt0_SO, Gnt1_SO, RValid0_SO, RValid1_SO, RData0_DO, RData1_DO,
               Busy_SO, CSel_SO, WrEn_SO, Addr_DO, WrData_DO
    );

    modport master (
        output Req0_SI, Req1_SI, We0_SI, We1_SI, Addr0_DI, Addr1_DI,
               BEn0_SI, BEn1_SI, WData0_DI, WData1_DI, RdData_DI,
        input  Gnt0_SO, Gnt1_SO, RValid0_SO, RValid1_SO, RData0_DO, RData1_DO,
               Busy_SO, CSel_SO, WrEn_SO, Addr_DO, WrData_DO
    );
endinterface

// File: rtl/sram_rmw_arbiter.sv
// rtl/sram_rmw_arbiter.sv - round-robin arbiter for one single-port SRAM with read-modify-write byte writes
//
// Purpose: shares one SRAM wrapper between two requesters. Reads take one cycle
// of latency, full-word writes take one cycle, partial-byte writes become a
// read followed by a merged write (RMW_WR state, Busy_SO high, no grants).
// Ports:
//   Clk_CI   clock
//   Rst_RBI  synchronous active-low reset
//   bus      sram_rmw_arbiter_if.slave (requesters + SRAM wrapper)
module sram_rmw_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RBI,
    sram_rmw_arbiter_if.slave    bus
);
    localparam int NB = DATA_W / 8;

    typedef enum logic {IDLE, RMW_WR} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic [NB-1:0]     rmw_ben_q, rmw_ben_d;
    logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;

    logic              sel1;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [NB-1:0]     req_ben;
    logic [DATA_W-1:0] req_wdata;

    // Read data is passed straight through; it is only qualified by RValid.
    assign bus.RValid0_SO = rvalid0_q;
    assign bus.RValid1_SO = rvalid1_q;
    assign bus.RData0_DO  = bus.RdData_DI;
    assign bus.RData1_DO  = bus.RdData_DI;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rvalid0_d     = 1'b0;
        rvalid1_d     = 1'b0;
        rmw_addr_d    = rmw_addr_q;
        rmw_ben_d     = rmw_ben_q;
        rmw_wdata_d   = rmw_wdata_q;
        bus.Gnt0_SO   = 1'b0;
        bus.Gnt1_SO   = 1'b0;
        bus.Busy_SO   = 1'b0;
        bus.CSel_SO   = 1'b0;
        bus.WrEn_SO   = 1'b0;
        bus.Addr_DO   = '0;
        bus.WrData_DO = '0;

        // Port 1 wins when it is the only requester or the pointer names it.
        sel1      = bus.Req1_SI && (!bus.Req0_SI || ptr_q);
        req_we    = sel1 ? bus.We1_SI    : bus.We0_SI;
        req_addr  = sel1 ? bus.Addr1_DI  : bus.Addr0_DI;
        req_ben   = sel1 ? bus.BEn1_SI   : bus.BEn0_SI;
        req_wdata = sel1 ? bus.WData1_DI : bus.WData0_DI;

        case (state_q)
            IDLE: begin
                if (bus.Req0_SI || bus.Req1_SI) begin
                    bus.Gnt0_SO = !sel1;
                    bus.Gnt1_SO = sel1;
                    ptr_d       = !sel1;
                    if (!req_we) begin
                        bus.CSel_SO = 1'b1;
                        bus.Addr_DO = req_addr;
                        rvalid0_d   = !sel1;
                        rvalid1_d   = sel1;
                    end else if (&req_ben) begin
                        bus.CSel_SO   = 1'b1;
                        bus.WrEn_SO   = 1'b1;
                        bus.Addr_DO   = req_addr;
                        bus.WrData_DO = req_wdata;
                    end else if (req_ben != '0) begin
                        // Fetch the old word now; merge it next cycle.
                        bus.CSel_SO = 1'b1;
                        bus.Addr_DO = req_addr;
                        rmw_addr_d  = req_addr;
                        rmw_ben_d   = req_ben;
                        rmw_wdata_d = req_wdata;
                        state_d     = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                bus.Busy_SO = 1'b1;
                bus.CSel_SO = 1'b1;
                bus.WrEn_SO = 1'b1;
                bus.Addr_DO = rmw_addr_q;
                for (int b = 0; b < NB; b++) begin
                    bus.WrData_DO[b*8 +: 8] = rmw_ben_q[b] ? rmw_wdata_q[b*8 +: 8]
                                                           : bus.RdData_DI[b*8 +: 8];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset must keep the SRAM and requesters quiet, including a pending merge.
        if (!Rst_RBI) begin
            bus.Gnt0_SO = 1'b0;
            bus.Gnt1_SO = 1'b0;
            bus.Busy_SO = 1'b0;
            bus.CSel_SO = 1'b0;
            bus.WrEn_SO = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rmw_addr_q  <= '0;
            rmw_ben_q   <= '0;
            rmw_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rmw_addr_q  <= rmw_addr_d;
            rmw_ben_q   <= rmw_ben_d;
            rmw_wdata_q <= rmw_wdata_d;
        end
    end
endmodule

// File: tb/tb_sram_rmw_arbiter.sv
// tb/tb_sram_rmw_arbiter.sv - directed self-checking bench for sram_rmw_arbiter
module tb_sram_rmw_arbiter;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    logic [63:0] mem [256];
    logic        pre_en;
    logic [7:0]  pre_addr;
    logic [63:0] pre_data;

    sram_rmw_arbiter_if #(.ADDR_W(8), .DATA_W(64)) bus ();

    sram_rmw_arbiter #(.ADDR_W(8), .DATA_W(64)) dut (
        .Clk_CI  (clk),
        .Rst_RBI (rstn),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM wrapper model: synchronous, one-cycle read latency, no byte mask.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.CSel_SO) begin
            if (bus.WrEn_SO) mem[bus.Addr_DO] <= bus.WrData_DO;
            else             bus.RdData_DI   <= mem[bus.Addr_DO];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [63:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_en   = 1'b0;
    endtask

    task automatic set_port(input int p, input logic req, input logic we, input logic [7:0] a,
                            input logic [7:0] ben, input logic [63:0] d);
        if (p == 0) begin
            bus.Req0_SI = req; bus.We0_SI = we; bus.Addr0_DI = a; bus.BEn0_SI = ben; bus.WData0_DI = d;
        end else begin
            bus.Req1_SI = req; bus.We1_SI = we; bus.Addr1_DI = a; bus.BEn1_SI = ben; bus.WData1_DI = d;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        pre_en    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        bus.RdData_DI = '0;
        set_port(0, 1'b1, 1'b0, 8'h00, 8'h00, 64'h0);
        set_port(1, 1'b1, 1'b0, 8'h00, 8'h00, 64'h0);

        // Reset with both requesting; preload the model meanwhile.
        step();
        preload(8'h00, 64'h0);
        preload(8'h10, 64'h0123456789ABCDEF);
        preload(8'h20, 64'h1111111111111111);
        preload(8'h32, 64'h2222222222222222);
        preload(8'h40, 64'h4444444444444444);
        preload(8'h50, 64'h5555555555555555);
        #1;
        check("rst_gnt0", bus.Gnt0_SO, 0);
        check("rst_gnt1", bus.Gnt1_SO, 0);
        check("rst_csel", bus.CSel_SO, 0);
        check("rst_busy", bus.Busy_SO, 0);
        check("rst_rv0", bus.RValid0_SO, 0);
        check("rst_rv1", bus.RValid1_SO, 0);
        step();
        rstn = 1'b1;
        #1;
        check("rel_gnt0", bus.Gnt0_SO, 1);
        check("rel_gnt1", bus.Gnt1_SO, 0);
        step();
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        #1;
        check("rel_rv0", bus.RValid0_SO, 1);

        // Read latency, port 1.
        set_port(1, 1'b1, 1'b0, 8'h10, 8'h00, 64'h0);
        #1;
        check("rd_gnt1", bus.Gnt1_SO, 1);
        check("rd_csel", bus.CSel_SO, 1);
        check("rd_wren", bus.WrEn_SO, 0);
        check("rd_addr", bus.Addr_DO, 64'h10);
        step();
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        #1;
        check("rd_rv1", bus.RValid1_SO, 1);
        check("rd_rv0", bus.RValid0_SO, 0);
        check("rd_data", bus.RData1_DO, 64'h0123456789ABCDEF);

        // Partial write, port 0; port 1 reads the same word right behind it.
        set_port(0, 1'b1, 1'b1, 8'h20, 8'h0F, 64'hAAAAAAAABBBBBBBB);
        #1;
        check("pw_gnt0", bus.Gnt0_SO, 1);
        check("pw_rd_csel", bus.CSel_SO, 1);
        check("pw_rd_wren", bus.WrEn_SO, 0);
        step();
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        set_port(1, 1'b1, 1'b0, 8'h20, 8'h00, 64'h0);
        #1;
        check("pw_busy", bus.Busy_SO, 1);
        check("pw_wren", bus.WrEn_SO, 1);
        check("pw_csel", bus.CSel_SO, 1);
        check("pw_nogrant", bus.Gnt1_SO, 0);
        check("pw_addr", bus.Addr_DO, 64'h20);
        check("pw_wdata", bus.WrData_DO, 64'h11111111BBBBBBBB);
        step();
        #1;
        check("pw_rb_gnt1", bus.Gnt1_SO, 1);
        check("pw_rb_busy", bus.Busy_SO, 0);
        step();
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        #1;
        check("pw_rb_rv1", bus.RValid1_SO, 1);
        check("pw_rb_data", bus.RData1_DO, 64'h11111111BBBBBBBB);

        // Round-robin with full-word writes from both ports.
        set_port(0, 1'b1, 1'b1, 8'h30, 8'hFF, 64'h3030303030303030);
        set_port(1, 1'b1, 1'b1, 8'h31, 8'hFF, 64'h3131313131313131);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_gnt0_%0d", i), bus.Gnt0_SO, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr_gnt1_%0d", i), bus.Gnt1_SO, (i % 2 == 1) ? 1 : 0);
            check($sformatf("rr_wren_%0d", i), bus.WrEn_SO, 1);
            step();
        end
        check("rr_mem30", mem[8'h30], 64'h3030303030303030);
        check("rr_mem31", mem[8'h31], 64'h3131313131313131);

        // Mixed: port 0 partial write, then RMW cycle with no grants, then port 1.
        set_port(0, 1'b1, 1'b1, 8'h32, 8'h01, 64'h00000000000000CC);
        #1;
        check("mx_gnt0", bus.Gnt0_SO, 1);
        step();
        #1;
        check("mx_rmw_gnt0", bus.Gnt0_SO, 0);
        check("mx_rmw_gnt1", bus.Gnt1_SO, 0);
        check("mx_rmw_busy", bus.Busy_SO, 1);
        step();
        #1;
        check("mx_gnt1", bus.Gnt1_SO, 1);
        check("mx_gnt0_off", bus.Gnt0_SO, 0);
        step();
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        check("mx_mem32", mem[8'h32], 64'h22222222222222CC);

        // BEn = 0: granted, no SRAM access.
        set_port(0, 1'b1, 1'b1, 8'h40, 8'h00, 64'hFFFFFFFFFFFFFFFF);
        #1;
        check("be0_gnt0", bus.Gnt0_SO, 1);
        check("be0_csel", bus.CSel_SO, 0);
        step();
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        check("be0_mem", mem[8'h40], 64'h4444444444444444);

        // Full write to the top address, then immediate readback.
        set_port(1, 1'b1, 1'b1, 8'hFF, 8'hFF, 64'hDEADBEEFCAFEF00D);
        #1;
        check("top_gnt1", bus.Gnt1_SO, 1);
        check("top_wren", bus.WrEn_SO, 1);
        check("top_addr", bus.Addr_DO, 64'hFF);
        step();
        set_port(1, 1'b1, 1'b0, 8'hFF, 8'h00, 64'h0);
        #1;
        check("top_busy", bus.Busy_SO, 0);
        check("top_rd_gnt1", bus.Gnt1_SO, 1);
        step();
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        #1;
        check("top_rv1", bus.RValid1_SO, 1);
        check("top_data", bus.RData1_DO, 64'hDEADBEEFCAFEF00D);

        // Reset during the merge write: suppressed, pointer back to 0.
        set_port(0, 1'b1, 1'b1, 8'h50, 8'hF0, 64'h0);
        #1;
        check("rr_pw_gnt0", bus.Gnt0_SO, 1);
        step();
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        rstn = 1'b0;
        #1;
        check("mr_csel", bus.CSel_SO, 0);
        check("mr_busy", bus.Busy_SO, 0);
        step();
        rstn = 1'b1;
        set_port(0, 1'b1, 1'b0, 8'h50, 8'h00, 64'h0);
        set_port(1, 1'b1, 1'b0, 8'h50, 8'h00, 64'h0);
        #1;
        check("mr_gnt0", bus.Gnt0_SO, 1);
        check("mr_gnt1", bus.Gnt1_SO, 0);
        step();
        set_port(0, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        set_port(1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        #1;
        check("mr_mem", mem[8'h50], 64'h5555555555555555);
        check("mr_rv0", bus.RValid0_SO, 1);
        check("mr_data", bus.RData0_DO, 64'h5555555555555555);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
